// File: rtl/timer_count_unit_if.sv
// Control/status bundle between the timer register block (master) and the
// timer counting core (slave).
interface timer_count_unit_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       cks;
  logic             en;
  logic             load;
  logic             updown;
  logic [WIDTH-1:0] tdr;
  logic [WIDTH-1:0] cnt;
  logic             clk_in;
  logic             ovf;
  logic             udf;

  modport master (
    output cks, en, load, updown, tdr,
    input  cnt, clk_in, ovf, udf
  );

  modport slave (
    input  cks, en, load, updown, tdr,
    output cnt, clk_in, ovf, udf
  );
endinterface

// File: rtl/timer_count_unit.sv
// Counting core of the timer: free-running pclk prescaler producing a tick
// enable, feeding a loadable up/down counter with one-cycle wrap flags.
module timer_count_unit #(
  parameter int WIDTH = 16
) (
  input  logic               pclk,
  input  logic               preset,
  timer_count_unit_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [3:0]       div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [3:0]       tick_mask;
  logic             tick;

  // Tick is a decode of the low k+1 divider bits all being one, so a cks
  // change simply re-decodes the same free-running divider without a restart.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    tick_mask = 4'b0001;
    unique case (bus.cks)
      2'b00:   tick_mask = 4'b0001;
      2'b01:   tick_mask = 4'b0011;
      2'b10:   tick_mask = 4'b0111;
      default: tick_mask = 4'b1111;
    endcase
    tick = &(div_q | ~tick_mask);
  end

  always_comb begin
    div_d = div_q + 4'd1;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (bus.load) begin
      cnt_d = bus.tdr;
    end else if (bus.en && tick) begin
      if (!bus.updown) begin
        cnt_d = cnt_q + CNT_ONE;
        ovf_d = (cnt_q == CNT_MAX);
      end else begin
        cnt_d = cnt_q - CNT_ONE;
        udf_d = (cnt_q == CNT_ZERO);
      end
    end
  end

  always_ff @(posedge pclk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    if (preset) begin
      div_q <= 4'd0;
      cnt_q <= CNT_ZERO;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.cnt    = cnt_q;
  assign bus.ovf    = ovf_q;
  assign bus.udf    = udf_q;
  assign bus.clk_in = div_q[bus.cks];

endmodule

// File: tb/tb_timer_count_unit.sv
// Directed bench for timer_count_unit at WIDTH=4: a cycle-by-cycle vector
// table plus sequences for prescale sweep, full up-count wrap and mid-count reset.
module tb_timer_count_unit;

  localparam int W = 4;

  logic pclk = 1'b0;
  logic preset;

  timer_count_unit_if #(.WIDTH(W)) bus ();

  timer_count_unit #(.WIDTH(W)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic         preset;
    logic         en;
    logic         load;
    logic         updown;
    logic [1:0]   cks;
    logic [W-1:0] tdr;
    logic [W-1:0] exp_cnt;
    logic         exp_ovf;
    logic         exp_udf;
    logic         exp_clk_in;
  } vec_t;

  vec_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pclk edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic p, input logic e, input logic l, input logic u,
                       input logic [1:0] c, input logic [W-1:0] t);
    preset     = p;
    bus.en     = e;
    bus.load   = l;
    bus.updown = u;
    bus.cks    = c;
    bus.tdr    = t;
  endtask

  task automatic add(input logic p, input logic e, input logic l, input logic u,
                     input logic [1:0] c, input logic [W-1:0] t,
                     input logic [W-1:0] ec, input logic eo, input logic eu, input logic ek);
    vec_t v;
    v.preset = p; v.en = e; v.load = l; v.updown = u; v.cks = c; v.tdr = t;
    v.exp_cnt = ec; v.exp_ovf = eo; v.exp_udf = eu; v.exp_clk_in = ek;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    step();
    preset = 1'b0;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd3);

    //   p  en ld ud cks tdr   cnt ovf udf clk_in
    add(1, 0, 0, 0, 1, 3,    0, 0, 0, 0);  // reset held 3 cycles
    add(1, 0, 0, 0, 1, 3,    0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 3,    0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 3,    0, 0, 0, 0);  // en=0: hold, prescaler runs
    add(0, 0, 0, 0, 1, 3,    0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 3,    0, 0, 0, 1);
    add(0, 1, 0, 0, 1, 3,    1, 0, 0, 0);  // 4th edge after release ticks
    add(0, 1, 0, 0, 1, 3,    1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 3,    1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 3,    1, 0, 0, 1);
    add(0, 1, 0, 0, 1, 3,    2, 0, 0, 0);
    add(0, 1, 0, 0, 1, 3,    2, 0, 0, 0);
    add(0, 1, 0, 0, 1, 3,    2, 0, 0, 1);
    add(0, 1, 0, 0, 1, 3,    2, 0, 0, 1);
    add(0, 1, 1, 0, 1, 9,    9, 0, 0, 0);  // load coincides with tick
    add(0, 0, 0, 0, 1, 9,    9, 0, 0, 0);  // en=0 across a tick
    add(0, 0, 0, 0, 1, 9,    9, 0, 0, 1);
    add(0, 0, 0, 0, 1, 9,    9, 0, 0, 1);
    add(0, 0, 0, 0, 1, 9,    9, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3,    3, 0, 0, 1);  // load 3, then count down /2
    add(0, 1, 0, 1, 0, 3,    2, 0, 0, 0);
    add(0, 1, 0, 1, 0, 3,    2, 0, 0, 1);
    add(0, 1, 0, 1, 0, 3,    1, 0, 0, 0);
    add(0, 1, 0, 1, 0, 3,    1, 0, 0, 1);
    add(0, 1, 0, 1, 0, 3,    0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 3,    0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 3,   15, 0, 1, 0);  // underflow 0->15
    add(0, 1, 0, 1, 0, 3,   15, 0, 0, 1);
    add(0, 1, 0, 1, 0, 3,   14, 0, 0, 0);
    add(0, 1, 0, 1, 3, 3,   14, 0, 0, 1);  // cks switch to /16, no tick
    add(0, 1, 1, 0, 3, 15,  15, 0, 0, 1);
    add(0, 1, 0, 0, 0, 15,  15, 0, 0, 1);
    add(0, 1, 0, 0, 0, 15,   0, 1, 0, 0);  // overflow 15->0
    add(0, 1, 0, 0, 0, 15,   0, 0, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].preset, tbl[i].en, tbl[i].load, tbl[i].updown, tbl[i].cks, tbl[i].tdr);
      step();
      check($sformatf("v%0d cnt", i),    32'(bus.cnt),    32'(tbl[i].exp_cnt));
      check($sformatf("v%0d ovf", i),    32'(bus.ovf),    32'(tbl[i].exp_ovf));
      check($sformatf("v%0d udf", i),    32'(bus.udf),    32'(tbl[i].exp_udf));
      check($sformatf("v%0d clk_in", i), 32'(bus.clk_in), 32'(tbl[i].exp_clk_in));
    end

    // Prescale sweep: tick spacing and clk_in period both 2^(k+1).
    for (int k = 0; k < 4; k++) begin
      int period;
      int t1, t2, r1, r2;
      logic [W-1:0] prev_cnt;
      logic prev_clk;
      period = 2 << k;
      t1 = 0; t2 = 0; r1 = 0; r2 = 0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 2'(k), 4'd0);
      do_reset();
      prev_cnt = bus.cnt;
      prev_clk = bus.clk_in;
      for (int e = 1; e <= 64; e++) begin
        step();
        if (bus.cnt != prev_cnt) begin
          if (t1 == 0) t1 = e; else if (t2 == 0) t2 = e;
        end
        if (!prev_clk && bus.clk_in) begin
          if (r1 == 0) r1 = e; else if (r2 == 0) r2 = e;
        end
        prev_cnt = bus.cnt;
        prev_clk = bus.clk_in;
        if (t2 != 0 && r2 != 0) break;
      end
      check($sformatf("cks%0d first tick edge", k), 32'(t1), 32'(period));
      check($sformatf("cks%0d tick spacing", k), 32'(t2 - t1), 32'(period));
      check($sformatf("cks%0d clk_in period", k), 32'(r2 - r1), 32'(period));
    end

    // Full up-count from 0 at /4 through the 15->0 wrap.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd3);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] now_v, nxt_v;
      now_v = W'(i);
      nxt_v = W'(i + 1);
      for (int j = 0; j < 4; j++) begin
        step();
        if (j < 3) begin
          check($sformatf("up%0d.%0d cnt", i, j), 32'(bus.cnt), 32'(now_v));
          check($sformatf("up%0d.%0d ovf", i, j), 32'(bus.ovf), 32'd0);
        end else begin
          check($sformatf("up%0d tick cnt", i), 32'(bus.cnt), 32'(nxt_v));
          check($sformatf("up%0d tick ovf", i), 32'(bus.ovf), (i == 15) ? 32'd1 : 32'd0);
        end
      end
    end
    step();
    check("ovf after wrap drops", 32'(bus.ovf), 32'd0);
    check("cnt after wrap", 32'(bus.cnt), 32'd0);

    // Reset for 7 cycles mid-count at /8, then restart from phase 0.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0);
    do_reset();
    for (int e = 0; e < 20; e++) step();
    check("mid-count cnt before reset", 32'(bus.cnt), 32'd2);
    preset = 1'b1;
    for (int e = 0; e < 7; e++) begin
      step();
      check($sformatf("in reset %0d cnt", e), 32'(bus.cnt), 32'd0);
      check($sformatf("in reset %0d clk_in", e), 32'(bus.clk_in), 32'd0);
    end
    preset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("post reset edge %0d cnt", e), 32'(bus.cnt), (e == 8) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
